// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access at a time into a single aligned 32-bit bus
// transaction, with alignment/funct3 checking, a response timeout and load extension.
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state, state_next;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [CW-1:0] count;

  logic          accept;
  logic          req_bad;
  logic          timeout_hit;
  logic [3:0]    be_raw;
  logic [31:0]   wdata_raw;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_data;

  assign req_ready   = (state == IDLE) && !rst;
  assign accept      = req_valid && req_ready;
  assign busy        = (state != IDLE);
  assign timeout_hit = (count == CW'(TIMEOUT - 1));

  // Illegal encodings and misalignment are judged on the live request at handshake time
  always_comb begin
    req_bad = 1'b1;
    case (req_funct3)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = req_addr[0];
      3'b010:  req_bad = (req_addr[1:0] != 2'b00);
      3'b100:  req_bad = req_we;
      3'b101:  req_bad = req_we | req_addr[0];
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = req_bad ? RESP : ISSUE;
      ISSUE: if (mem_gnt) state_next = WAIT;
      WAIT:  if (mem_rvalid || timeout_hit) state_next = RESP;
      RESP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      count    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          count <= '0;
          if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            rdata_q  <= 32'h0;
            err_q    <= req_bad;
          end
        end
        WAIT: begin
          count <= count + CW'(1);
          if (mem_rvalid)       rdata_q <= mem_rdata;
          else if (timeout_hit) err_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    be_raw    = 4'b1111;
    wdata_raw = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be_raw    = 4'b0001 << addr_q[1:0];
        wdata_raw = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_raw    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_raw = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Bus fields are only driven while the request is outstanding, so they idle at zero
  assign mem_req   = (state == ISSUE);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be    = mem_req ? be_raw : 4'b0000;
  assign mem_wdata = mem_req ? wdata_raw : 32'h0;

  always_comb begin
    byte_sel = rdata_q[7:0];
    case (addr_q[1:0])
      2'b01:   byte_sel = rdata_q[15:8];
      2'b10:   byte_sel = rdata_q[23:16];
      2'b11:   byte_sel = rdata_q[31:24];
      default: byte_sel = rdata_q[7:0];
    endcase
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: stores, load extension, errors, timeout,
// mid-transaction reset and back-to-back request spacing.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] exp;
  } ld_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] wexp;
    int          delay;
  } st_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr;
  } er_vec_t;

  // Advance one clock and settle just after the edge, where outputs are sampled and inputs driven
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
  endtask

  task automatic drop_req();
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks++;
    if ({req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %b expected 000000", {req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err});
    end
    n_checks++;
    if ({mem_be, mem_addr, mem_wdata, rsp_rdata} !== 100'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_buses: got be=%h addr=%h wdata=%h rdata=%h expected all 0", mem_be, mem_addr, mem_wdata, rsp_rdata);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_store_word();
    put_req(1'b1, 3'b010, 32'h1000_0008, 32'hDEAD_BEEF);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sw_ready: got %b expected 1", req_ready);
    end
    step();
    drop_req();
    n_checks++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b1111, 32'h1000_0008, 32'hDEAD_BEEF}) begin
      n_fail++;
      $display("[TB] FAIL sw_issue: got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 1111 10000008 deadbeef",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    n_checks++;
    if ({mem_req, busy, rsp_valid} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL sw_wait: got req/busy/rsp=%b expected 010", {mem_req, busy, rsp_valid});
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL sw_resp: got valid=%b err=%b rdata=%h expected 1 0 00000000", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
    n_checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL sw_done: got valid/busy/ready=%b expected 001", {rsp_valid, busy, req_ready});
    end
  endtask

  task automatic test_loads();
    ld_vec_t v [7];
    v[0] = '{3'b000, 32'h5000_0003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80};
    v[1] = '{3'b100, 32'h5000_0003, 32'h80FF_1234, 4'b1000, 32'h0000_0080};
    v[2] = '{3'b101, 32'h5000_0002, 32'h80FF_1234, 4'b1100, 32'h0000_80FF};
    v[3] = '{3'b001, 32'h5000_0002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF};
    v[4] = '{3'b000, 32'h5000_0000, 32'h80FF_1234, 4'b0001, 32'h0000_0034};
    v[5] = '{3'b001, 32'h5000_0000, 32'h80FF_9234, 4'b0011, 32'hFFFF_9234};
    v[6] = '{3'b010, 32'h5000_0004, 32'h80FF_1234, 4'b1111, 32'h80FF_1234};
    for (int i = 0; i < 7; i++) begin
      put_req(1'b0, v[i].f3, v[i].addr, 32'hAAAA_AAAA);
      step();
      drop_req();
      n_checks++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, v[i].be, v[i].addr[31:2], 2'b00}) begin
        n_fail++;
        $display("[TB] FAIL load%0d_issue: got req=%b we=%b be=%b addr=%h expected 1 0 %b %h",
                 i, mem_req, mem_we, mem_be, mem_addr, v[i].be, {v[i].addr[31:2], 2'b00});
      end
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = v[i].rdata;
      step();
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, v[i].exp}) begin
        n_fail++;
        $display("[TB] FAIL load%0d_data: got valid=%b err=%b rdata=%h expected 1 0 %h",
                 i, rsp_valid, rsp_err, rsp_rdata, v[i].exp);
      end
      step();
    end
  endtask

  task automatic test_stores_gnt_delay();
    st_vec_t v [4];
    v[0] = '{3'b000, 32'h2000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 3};
    v[1] = '{3'b001, 32'h2000_0006, 32'h1234_BEEF, 4'b1100, 32'hBEEF_BEEF, 1};
    v[2] = '{3'b000, 32'h2000_0003, 32'h0000_0077, 4'b1000, 32'h7777_7777, 0};
    v[3] = '{3'b001, 32'h2000_0000, 32'h0000_CAFE, 4'b0011, 32'hCAFE_CAFE, 0};
    for (int i = 0; i < 4; i++) begin
      put_req(1'b1, v[i].f3, v[i].addr, v[i].wdata);
      step();
      drop_req();
      for (int d = 0; d <= v[i].delay; d++) begin
        n_checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, v[i].be, v[i].addr[31:2], 2'b00, v[i].wexp}) begin
          n_fail++;
          $display("[TB] FAIL store%0d_issue_c%0d: got req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 %b %h %h",
                   i, d, mem_req, mem_we, mem_be, mem_addr, mem_wdata, v[i].be, {v[i].addr[31:2], 2'b00}, v[i].wexp);
        end
        if (d == v[i].delay) mem_gnt = 1'b1;
        step();
      end
      mem_gnt = 1'b0;
      n_checks++;
      if (mem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL store%0d_wait_req: got %b expected 0", i, mem_req);
      end
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      step();
      mem_rvalid = 1'b0;
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("[TB] FAIL store%0d_resp: got valid=%b err=%b rdata=%h expected 1 0 00000000", i, rsp_valid, rsp_err, rsp_rdata);
      end
      step();
    end
  endtask

  task automatic test_errors();
    er_vec_t v [6];
    v[0] = '{3'b010, 1'b0, 32'h4000_0002};
    v[1] = '{3'b011, 1'b0, 32'h4000_0000};
    v[2] = '{3'b100, 1'b1, 32'h4000_0000};
    v[3] = '{3'b001, 1'b0, 32'h4000_0001};
    v[4] = '{3'b010, 1'b1, 32'h4000_0001};
    v[5] = '{3'b110, 1'b0, 32'h4000_0000};
    for (int i = 0; i < 6; i++) begin
      put_req(v[i].we, v[i].f3, v[i].addr, 32'h1111_1111);
      step();
      drop_req();
      mem_gnt = 1'b1;
      n_checks++;
      if ({rsp_valid, rsp_err, mem_req, rsp_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        n_fail++;
        $display("[TB] FAIL err%0d_resp: got valid=%b err=%b mem_req=%b rdata=%h expected 1 1 0 00000000",
                 i, rsp_valid, rsp_err, mem_req, rsp_rdata);
      end
      step();
      mem_gnt = 1'b0;
      n_checks++;
      if ({rsp_valid, busy, mem_req, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("[TB] FAIL err%0d_after: got valid/busy/req/ready=%b expected 0001", i, {rsp_valid, busy, mem_req, req_ready});
      end
    end
  endtask

  task automatic test_timeout();
    int hit;
    hit = 0;
    put_req(1'b0, 3'b010, 32'h3000_0004, 32'h0);
    step();
    drop_req();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rsp_valid === 1'b1) begin
        hit = i;
        break;
      end
    end
    n_checks++;
    if (hit != 16) begin
      n_fail++;
      $display("[TB] FAIL timeout_latency: got rsp_valid after %0d wait cycles expected 16 (0 = none within 40)", hit);
    end
    n_checks++;
    if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("[TB] FAIL timeout_resp: got err=%b rdata=%h expected 1 00000000", rsp_err, rsp_rdata);
    end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    step();
    n_checks++;
    if ({rsp_valid, busy, mem_req, req_ready} !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL timeout_late_rvalid: got valid/busy/req/ready=%b expected 0001", {rsp_valid, busy, mem_req, req_ready});
    end
  endtask

  task automatic test_reset_mid();
    put_req(1'b0, 3'b010, 32'h6000_0000, 32'h0);
    step();
    drop_req();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    step();
    n_checks++;
    if ({req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err, mem_be, mem_addr, mem_wdata, rsp_rdata} !== 106'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_outputs: got ready=%b busy=%b req=%b we=%b valid=%b err=%b be=%b addr=%h wd=%h rd=%h expected all 0",
               req_ready, busy, mem_req, mem_we, rsp_valid, rsp_err, mem_be, mem_addr, mem_wdata, rsp_rdata);
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_recover: got valid/busy/ready=%b expected 001", {rsp_valid, busy, req_ready});
    end
    mem_rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    put_req(1'b0, 3'b010, 32'h7000_0002, 32'h0);
    step();
    n_checks++;
    if ({rsp_valid, req_ready} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL b2b_resp_ready: got valid/ready=%b expected 10", {rsp_valid, req_ready});
    end
    put_req(1'b0, 3'b000, 32'h7000_0000, 32'h0);
    step();
    n_checks++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle_gap: got valid/busy/ready=%b expected 001", {rsp_valid, busy, req_ready});
    end
    step();
    drop_req();
    n_checks++;
    if ({mem_req, mem_be} !== {1'b1, 4'b0001}) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_issue: got req=%b be=%b expected 1 0001", mem_req, mem_be);
    end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_00F0;
    step();
    mem_rvalid = 1'b0;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hFFFF_FFF0}) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_resp: got valid=%b err=%b rdata=%h expected 1 0 fffffff0", rsp_valid, rsp_err, rsp_rdata);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_stores_gnt_delay();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in WAIT without mem_rvalid before bus error.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents an access.
REQ-005 req_ready  output  1  unit accepts an access this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  misaligned, illegal funct3, or timeout; valid with rsp_valid.
REQ-013 busy  output  1  stall to core; high whenever state != IDLE.
REQ-014 mem_req / mem_we  output  1 each  bus request and write enable.
REQ-015 mem_addr  output  32  {addr[31:2], 2'b00}.
REQ-016 mem_be / mem_wdata  output  4 / 32  byte enables and lane-replicated write data.
REQ-017 mem_gnt / mem_rvalid  input  1 each  request accepted / access completed.
REQ-018 mem_rdata  input  32  read word, valid with mem_rvalid.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, RESP; req_ready = (state==IDLE) and not rst.
REQ-020 Handshake req_valid && req_ready captures we, funct3, addr, wdata into internal registers; inputs are ignored afterwards.
REQ-021 Captured access with illegal funct3 (011, 110, 111, or 1xx with req_we=1), half with addr[0]=1, or word with addr[1:0]!=0: IDLE -> RESP, rsp_err=1, mem_req never asserted.
REQ-022 Legal access: IDLE -> ISSUE; mem_req=1 and mem_we/addr/be/wdata held constant until mem_gnt sampled high, then -> WAIT.
REQ-023 Byte: mem_be = 4'b0001 << addr[1:0], mem_wdata = {4{wdata[7:0]}}; half: mem_be = addr[1] ? 4'b1100 : 4'b0011, mem_wdata = {2{wdata[15:0]}}; word: mem_be = 4'b1111, mem_wdata = wdata.
REQ-024 Loads use the same mem_be; mem_we=0.
REQ-025 WAIT: mem_req=0; mem_rvalid high -> RESP, latching mem_rdata; mem_rvalid is sampled only in WAIT.
REQ-026 WAIT cycle counter starts at 0 on entry; reaching TIMEOUT without mem_rvalid -> RESP with rsp_err=1, rsp_rdata=0.
REQ-027 RESP: rsp_valid=1 for exactly one cycle, then -> IDLE; rsp_* are 0 in every other state.
REQ-028 Load extraction: byte = rdata[8*addr[1:0] +: 8], half = rdata[16*addr[1] +: 16]; b/h sign-extend, bu/hu zero-extend, w unchanged.
REQ-029 Minimum legal latency: accept at cycle N, gnt at N+1, rvalid at N+2, rsp_valid at N+3; error path rsp_valid at N+1.
REQ-030 New request is accepted no earlier than the cycle after RESP; no back-to-back overlap.

Reset
REQ-031 rst high: state=IDLE, counter=0; mem_req, mem_we, mem_be, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_err, busy, req_ready all 0.
REQ-032 Reset mid-transaction abandons it: no rsp_valid; mem_req low the cycle after rst is sampled; late mem_rvalid while in IDLE is ignored.

Verification
REQ-033 sw addr=0x1000_0008 wdata=0xDEADBEEF, gnt immediate, rvalid next cycle -> mem_be=1111, mem_addr=0x10000008, rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
REQ-034 lb addr=0x...03, mem_rdata=0x80FF_1234 -> rsp_rdata=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x...02 -> 0x000080FF.
REQ-035 sb addr=0x...01 wdata=0x000000A5 -> mem_be=0010, mem_wdata=0xA5A5A5A5; gnt delayed 3 cycles -> mem_req and fields stable all 3 cycles.
REQ-036 lw addr=0x...02 -> rsp_valid at N+1 with rsp_err=1, mem_req never high.
REQ-037 lw with gnt but no rvalid for TIMEOUT=16 cycles -> rsp_err=1; later rvalid in IDLE ignored.
REQ-038 rst asserted in WAIT -> next cycle all outputs 0, no rsp_valid, req_ready=1 the cycle after rst drops.
